keypad_time_entry: RTL
======================

Name: keypad_time_entry

Overview:
- Sits directly downstream of the keypad BCD encoder.
- Consumes the encoder's 4-bit digit and its active-low key-valid flag, then debounces each key press.
- Shifts accepted digits into a 4-digit MM:SS cook-time register, right to left, as on a microwave panel.
- Holds the entered time until the countdown timer takes it, a clear is issued, or (optionally) entry times out.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable clocks needed to accept a press and to accept a release; legal range 2..255.
- TIMEOUT_CYCLES, 1000: idle clocks before a partial entry is discarded; used only with ENTRY_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- D  in  4  BCD digit from the encoder; 4'hF means no key.
- keyn  in  1  from the encoder; low = valid single key present, high = none or disabled.
- enablen  in  1  active-low entry enable; high blocks digit acceptance.
- clear  in  1  synchronous clear of the entry.
- take  in  1  one-cycle pulse; the timer samples the digit outputs this cycle.
- min_tens, min_ones, sec_tens, sec_ones  out  4 each  BCD digits.
- count  out  3  digits entered, 0..4.
- full  out  1  count == 4.
- strobe  out  1  one-cycle pulse when a digit is accepted.
- timeout  out  1  one-cycle pulse when entry is auto-cleared.

Behaviour:
- Reset (async, rst=1): all digit outputs 0, count 0, full/strobe/timeout 0, FSM in IDLE, internal counters 0.
- FSM states and transitions:
  - IDLE -> DEBOUNCE when keyn sampled low; latch D into d_hold and set db_cnt = 0.
  - DEBOUNCE: if keyn is high or D != d_hold, go to IDLE. Otherwise db_cnt increments each clock. On the edge where db_cnt == DEBOUNCE_CYCLES-1, go to HELD and perform the accept check.
  - Accept check: the digit is accepted if enablen == 0, d_hold <= 9 and count < 4. Otherwise the press is silently rejected; the FSM still goes to HELD.
  - HELD: stays while keyn is low. keyn high -> RELEASE with db_cnt = 0.
  - RELEASE: keyn low -> back to HELD. After DEBOUNCE_CYCLES consecutive high samples -> IDLE.
- Latency: counting the edge that first samples keyn low as edge 0, digits, count and strobe update at edge DEBOUNCE_CYCLES. strobe is high for exactly one cycle.
- Shift on accept, all in one edge:
  - min_tens <= min_ones
  - min_ones <= sec_tens
  - sec_tens <= sec_ones
  - sec_ones <= d_hold
  - count <= count + 1
- No arithmetic is performed. Digits are stored as entered; sec_tens > 5 is legal and is normalised downstream.
- Full: at count 4, further presses are rejected with no shift and no strobe, and full stays 1.
- Priority within one edge, highest first: rst > clear > take > accept.
- clear or take: all digits 0 and count 0 at the next edge. The FSM is unaffected, so a held key is not re-accepted. An accept that coincides with clear/take is discarded.
- take with count 0 is legal and has no effect.
- A key held indefinitely yields exactly one accept. A new digit needs a debounced release first.
- Glitch handling: a keyn low pulse shorter than DEBOUNCE_CYCLES returns to IDLE with no accept.

Optional Feature:
- Macro: ENTRY_TIMEOUT_EN.
- Defined:
  - idle_cnt increments each clock while the FSM is IDLE and count > 0.
  - idle_cnt resets to 0 on any accept, on clear/take, or when the FSM leaves IDLE.
  - When idle_cnt reaches TIMEOUT_CYCLES-1, digits and count are cleared and timeout pulses for one cycle.
- Not defined: no idle counter is built, and timeout is tied to 0.

Test Plan:
- DEBOUNCE_CYCLES=4: reset, then keyn low with D=5 held for 10 clocks, then released → strobe at edge 4 only; sec_ones=5, count=1; no second strobe.
- Enter 1,2,3,0 with a debounced release after each → min_tens=1, min_ones=2, sec_tens=3, sec_ones=0, full=1; a fifth key 7 → no strobe, digits unchanged.
- keyn low for 2 clocks, then D changes 3→4 mid-debounce → no strobe; a subsequent 6-clock press of D=4 → sec_ones=4.
- enablen=1 during a press of 8 → no strobe, count=0. The same press with D=4'hF and enablen=0 → rejected.
- count=2, then take and accept on the same edge → all digits 0, count=0, no strobe. rst asserted mid-DEBOUNCE → outputs 0 immediately (async).
- ENTRY_TIMEOUT_EN defined, TIMEOUT_CYCLES=20: enter digit 9, then idle → at idle clock 20 timeout pulses and count=0. With the macro undefined → digit retained and timeout stays 0.

Source files
------------

// File: rtl/keypad_time_entry.sv
// Debounces keypad presses and shifts accepted BCD digits into an MM:SS entry register.
// Optional idle auto-clear of a partial entry is built when ENTRY_TIMEOUT_EN is defined.
module keypad_time_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] D,
  input  logic       keyn,
  input  logic       enablen,
  input  logic       clear,
  input  logic       take,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [2:0] count,
  output logic       full,
  output logic       strobe,
  output logic       timeout
);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be in 2..255");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  localparam logic [7:0] DbLast = 8'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StDebounce, StHeld, StRelease} state_e;

  state_e     state_q, state_d;
  logic [3:0] d_hold_q, d_hold_d;
  logic [7:0] db_cnt_q, db_cnt_d;
  logic [3:0] min_tens_q, min_tens_d, min_ones_q, min_ones_d;
  logic [3:0] sec_tens_q, sec_tens_d, sec_ones_q, sec_ones_d;
  logic [2:0] count_q, count_d;
  logic       strobe_q, timeout_q;
  logic       press_done, accept, tmo_fire;

  always_comb begin
    state_d    = state_q;
    d_hold_d   = d_hold_q;
    db_cnt_d   = db_cnt_q;
    press_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!keyn) begin
          state_d  = StDebounce;
          d_hold_d = D;
          db_cnt_d = '0;
        end
      end
      StDebounce: begin
        if (keyn || D != d_hold_q) begin
          state_d = StIdle;
        end else if (db_cnt_q == DbLast) begin
          state_d    = StHeld;
          press_done = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + 8'd1;
        end
      end
      StHeld: begin
        if (keyn) begin
          state_d  = StRelease;
          db_cnt_d = '0;
        end
      end
      StRelease: begin
        if (!keyn) begin
          state_d = StHeld;
        end else if (db_cnt_q == DbLast) begin
          state_d = StIdle;
        end else begin
          db_cnt_d = db_cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // clear/take win over a coincident accept, so the press is simply lost
  assign accept = press_done && !enablen && (d_hold_q <= 4'd9) && (count_q < 3'd4)
                  && !clear && !take;

`ifdef ENTRY_TIMEOUT_EN
  localparam int unsigned IdleW = $clog2(TIMEOUT_CYCLES);
  localparam logic [IdleW-1:0] IdleLast = IdleW'(TIMEOUT_CYCLES - 1);

  logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;

  always_comb begin
    idle_cnt_d = '0;
    tmo_fire   = 1'b0;
    if (clear || take || accept || state_q != StIdle || state_d != StIdle
        || count_q == 3'd0) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q == IdleLast) begin
      tmo_fire = 1'b1;
    end else begin
      idle_cnt_d = idle_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) idle_cnt_q <= '0;
    else     idle_cnt_q <= idle_cnt_d;
  end
`else
  assign tmo_fire = 1'b0;
`endif

  always_comb begin
    min_tens_d = min_tens_q;
    min_ones_d = min_ones_q;
    sec_tens_d = sec_tens_q;
    sec_ones_d = sec_ones_q;
    count_d    = count_q;
    if (clear || take || tmo_fire) begin
      min_tens_d = '0;
      min_ones_d = '0;
      sec_tens_d = '0;
      sec_ones_d = '0;
      count_d    = '0;
    end else if (accept) begin
      min_tens_d = min_ones_q;
      min_ones_d = sec_tens_q;
      sec_tens_d = sec_ones_q;
      sec_ones_d = d_hold_q;
      count_d    = count_q + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      d_hold_q   <= '0;
      db_cnt_q   <= '0;
      min_tens_q <= '0;
      min_ones_q <= '0;
      sec_tens_q <= '0;
      sec_ones_q <= '0;
      count_q    <= '0;
      strobe_q   <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      d_hold_q   <= d_hold_d;
      db_cnt_q   <= db_cnt_d;
      min_tens_q <= min_tens_d;
      min_ones_q <= min_ones_d;
      sec_tens_q <= sec_tens_d;
      sec_ones_q <= sec_ones_d;
      count_q    <= count_d;
      strobe_q   <= accept;
      timeout_q  <= tmo_fire;
    end
  end

  assign min_tens = min_tens_q;
  assign min_ones = min_ones_q;
  assign sec_tens = sec_tens_q;
  assign sec_ones = sec_ones_q;
  assign count    = count_q;
  assign full     = (count_q == 3'd4);
  assign strobe   = strobe_q;
  assign timeout  = timeout_q;

endmodule
